// File: rtl/execute_hazard_unit.sv
// Execute-stage hazard unit: tracks in-flight destination tags, picks forwarding
// sources for Rn/Rm/Rs and stalls on load-use hazards.
module execute_hazard_unit #(
    parameter  int NUM_FWD  = 2,
    parameter  int REG_W    = 4,
    parameter  int LOAD_LAT = 1,
    parameter  int PC_REG   = 15,
    localparam int SW       = $clog2(NUM_FWD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [REG_W-1:0] rn,
    input  logic [REG_W-1:0] rm,
    input  logic [REG_W-1:0] rs,
    input  logic             use_rn,
    input  logic             use_rm,
    input  logic             use_rs,
    input  logic             wr_en,
    input  logic [REG_W-1:0] rd_in,
    input  logic             is_load,
    input  logic             flush,
    output logic [SW-1:0]    sel_A_in,
    output logic [SW-1:0]    sel_B_in,
    output logic [SW-1:0]    sel_shift_in,
    output logic             stall,
    output logic [15:0]      stall_count
);

    // Index k holds the tag for stage k+1 (index 0 = nearest stage).
    logic [NUM_FWD-1:0]            tag_valid_r;
    logic [NUM_FWD-1:0]            tag_load_r;
    logic [NUM_FWD-1:0][REG_W-1:0] tag_rd_r;

    logic [SW-1:0] sel_a_s;
    logic [SW-1:0] sel_b_s;
    logic [SW-1:0] sel_sh_s;
    logic          hazard_s;
    logic          stall_s;
    logic          enter_s;

    // Youngest matching stage wins, so scan from oldest to nearest.
    function automatic logic [SW-1:0] pick_stage(
        input logic                            use_src,
        input logic [REG_W-1:0]                src,
        input logic                            iv,
        input logic [NUM_FWD-1:0]              valid_v,
        input logic [NUM_FWD-1:0][REG_W-1:0]   rd_v
    );
        logic [SW-1:0] sel;
        sel = {SW{1'b0}};
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (use_src && iv && valid_v[k] && (rd_v[k] == src) &&
                (src != REG_W'(PC_REG))) begin
                sel = SW'(k + 1);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // A selected load is not yet forwardable while it sits at or before LOAD_LAT.
    function automatic logic load_hazard(
        input logic [SW-1:0]      sel,
        input logic [NUM_FWD-1:0] load_v
    );
        logic hz;
        hz = 1'b0;
        for (int k = 0; k < NUM_FWD; k++) begin
            if ((sel == SW'(k + 1)) && load_v[k] && ((k + 1) <= LOAD_LAT)) begin
                hz = 1'b1;
            end else begin
                hz = hz;
            end
        end
        return hz;
    endfunction

    // Operand source selection and load-use stall decision.
    always_comb begin
        sel_a_s  = pick_stage(use_rn, rn, instr_valid, tag_valid_r, tag_rd_r);
        sel_b_s  = pick_stage(use_rm, rm, instr_valid, tag_valid_r, tag_rd_r);
        sel_sh_s = pick_stage(use_rs, rs, instr_valid, tag_valid_r, tag_rd_r);
        hazard_s = load_hazard(sel_a_s, tag_load_r) |
                   load_hazard(sel_b_s, tag_load_r) |
                   load_hazard(sel_sh_s, tag_load_r);
        stall_s  = hazard_s & ~flush;
    end

    assign sel_A_in     = sel_a_s;
    assign sel_B_in     = sel_b_s;
    assign sel_shift_in = sel_sh_s;
    assign stall        = stall_s;
    assign enter_s      = instr_valid & wr_en & ~stall & ~flush;

    // Tag pipeline: shift every cycle; stalled or flushed instructions enter as bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= {NUM_FWD{1'b0}};
            tag_load_r  <= {NUM_FWD{1'b0}};
            tag_rd_r    <= {(NUM_FWD * REG_W){1'b0}};
        end else begin
            for (int k = NUM_FWD - 1; k >= 1; k--) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_load_r[k]  <= tag_load_r[k-1];
                tag_rd_r[k]    <= tag_rd_r[k-1];
            end
            tag_valid_r[0] <= enter_s;
            tag_load_r[0]  <= enter_s & is_load;
            tag_rd_r[0]    <= enter_s ? rd_in : {REG_W{1'b0}};
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end else begin
            stall_count <= stall_count;
        end
    end

endmodule

// File: tb/tb_execute_hazard_unit.sv
// Directed scoreboard bench for execute_hazard_unit with default parameters.
module tb_execute_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic [3:0] rn, rm, rs, rd_in;
    logic       use_rn, use_rm, use_rs, wr_en, is_load, flush;
    logic [1:0] sel_A_in, sel_B_in, sel_shift_in;
    logic       stall;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    execute_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .rn(rn), .rm(rm), .rs(rs),
        .use_rn(use_rn), .use_rm(use_rm), .use_rs(use_rs),
        .wr_en(wr_en), .rd_in(rd_in), .is_load(is_load), .flush(flush),
        .sel_A_in(sel_A_in), .sel_B_in(sel_B_in), .sel_shift_in(sel_shift_in),
        .stall(stall), .stall_count(stall_count)
    );

    typedef struct {
        string       tag;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [1:0]  s;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [1:0] a, input logic [1:0] b,
                            input logic [1:0] s, input logic st);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.s = s; e.st = st; e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            cmp({e.tag, "/sel_A"}, 16'(sel_A_in), 16'(e.a));
            cmp({e.tag, "/sel_B"}, 16'(sel_B_in), 16'(e.b));
            cmp({e.tag, "/sel_sh"}, 16'(sel_shift_in), 16'(e.s));
            cmp({e.tag, "/stall"}, 16'(stall), 16'(e.st));
            cmp({e.tag, "/cnt"}, stall_count, e.cnt);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] rn_v, input logic [3:0] rm_v,
                         input logic [3:0] rs_v, input logic urn, input logic urm,
                         input logic urs, input logic wr, input logic [3:0] rd,
                         input logic ld, input logic fl);
        instr_valid = iv; rn = rn_v; rm = rm_v; rs = rs_v;
        use_rn = urn; use_rm = urm; use_rs = urs;
        wr_en = wr; rd_in = rd; is_load = ld; flush = fl;
    endtask

    // One instruction cycle: drive, record expectation, check mid-cycle, clock.
    task automatic step(input string tag, input logic iv, input logic [3:0] rn_v,
                        input logic [3:0] rm_v, input logic [3:0] rs_v, input logic urn,
                        input logic urm, input logic urs, input logic wr,
                        input logic [3:0] rd, input logic ld, input logic fl,
                        input logic [1:0] ea, input logic [1:0] eb, input logic [1:0] es,
                        input logic est);
        drive(iv, rn_v, rm_v, rs_v, urn, urm, urs, wr, rd, ld, fl);
        push_exp(tag, ea, eb, es, est);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        if (est && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
        #1;
    endtask

    initial begin
        int tmp;
        exp_cnt = 16'd0;
        rst_n   = 1'b0;
        drive(1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        #2;
        push_exp("reset", 2'd0, 2'd0, 2'd0, 1'b0);
        pop_check();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back ALU forwarding
        step("alu_wr",   1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd3, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        step("alu_fwd1", 1, 4'd3, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
        step("unrel",    1, 4'd7, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd0, 0);

        // Youngest writer wins, then older writer visible at stage 2
        step("wr3_a",    1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd3, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        step("wr3_b",    1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd3, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        step("youngest", 1, 4'd0, 4'd3, 4'd0, 0, 1, 0, 0, 4'd0, 0, 0, 2'd0, 2'd1, 2'd0, 0);
        step("stage2",   1, 4'd0, 4'd3, 4'd0, 0, 1, 0, 0, 4'd0, 0, 0, 2'd0, 2'd2, 2'd0, 0);

        // Load-use on Rs: one stall cycle then forward from stage 2
        step("ldr5",     1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd5, 1, 0, 2'd0, 2'd0, 2'd0, 0);
        step("lu_stall", 1, 4'd0, 4'd0, 4'd5, 0, 0, 1, 0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd1, 1);
        step("lu_fwd2",  1, 4'd0, 4'd0, 4'd5, 0, 0, 1, 0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd2, 0);

        // Flush beats stall; flushed load-writer must not enter entry 1
        step("ldr5_b",   1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd5, 1, 0, 2'd0, 2'd0, 2'd0, 0);
        step("flush",    1, 4'd5, 4'd0, 4'd0, 1, 0, 0, 1, 4'd5, 1, 1, 2'd1, 2'd0, 2'd0, 0);
        step("post_fl",  1, 4'd5, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, 2'd2, 2'd0, 2'd0, 0);

        // PC never forwarded; unused source and invalid instruction never match
        step("wr15",     1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd15, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        step("rd15",     1, 4'd15, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        step("wr3_c",    1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd3, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        step("use0",     1, 4'd3, 4'd3, 4'd0, 0, 1, 0, 0, 4'd0, 0, 0, 2'd0, 2'd1, 2'd0, 0);
        step("iv0",      0, 4'd3, 4'd3, 4'd0, 1, 1, 0, 0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd0, 0);

        // Two operands hit the same load
        step("ldr6",     1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd6, 1, 0, 2'd0, 2'd0, 2'd0, 0);
        step("dual_st",  1, 4'd6, 4'd6, 4'd0, 1, 1, 0, 0, 4'd0, 0, 0, 2'd1, 2'd1, 2'd0, 1);
        step("dual_fw",  1, 4'd6, 4'd6, 4'd0, 1, 1, 0, 0, 4'd0, 0, 0, 2'd2, 2'd2, 2'd0, 0);

        // Reset in the middle of a stall
        step("ldr7",     1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd7, 1, 0, 2'd0, 2'd0, 2'd0, 0);
        drive(1, 4'd7, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0);
        push_exp("pre_rst", 2'd1, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        pop_check();
        #1 rst_n = 1'b0;
        exp_cnt = 16'd0;
        push_exp("mid_rst", 2'd0, 2'd0, 2'd0, 1'b0);
        #1 pop_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("post_rst", 1, 4'd7, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd0, 0);

        // Saturation: hold stall high for 70000 edges
        drive(0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0);
        force dut.stall = 1'b1;
        repeat (70000) @(posedge clk);
        #1 release dut.stall;
        tmp = int'(exp_cnt) + 70000;
        exp_cnt = (tmp > 65535) ? 16'hFFFF : 16'(tmp);
        push_exp("sat", 2'd0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        pop_check();
        @(posedge clk); #1;

        // Reset pulse clears the saturated counter and live forwarding
        step("wr3_d",    1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 4'd3, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        drive(1, 4'd3, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0);
        push_exp("pre_pulse", 2'd1, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        pop_check();
        #1 rst_n = 1'b0;
        exp_cnt = 16'd0;
        push_exp("pulse", 2'd0, 2'd0, 2'd0, 1'b0);
        #1 pop_check();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("after",    1, 4'd3, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, 2'd0, 2'd0, 2'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
